// File: rtl/mac_sequencer.sv
// Sequences one inference pass: streams weight/digit ROM words into the MAC, sums each neuron's
// partial products and hands one result per neuron to the output layer. Optional ARGMAX_EN adds class tracking.
module mac_sequencer #(
  parameter int unsigned N_NEURONS = 10,
  parameter int unsigned N_WORDS   = 4,
  parameter int unsigned MAC_LAT   = 2,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned ACC_W     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] digit_base,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [127:0]      w_data,
  output logic [ADDR_W-1:0] d_addr,
  input  logic [127:0]      d_data,
  output logic [127:0]      mac_a,
  output logic [127:0]      mac_b,
  input  logic [19:0]       mac_p,
  output logic [ACC_W-1:0]  result,
  output logic [7:0]        result_idx,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              busy,
  output logic              done
`ifdef ARGMAX_EN
  ,
  output logic [7:0]        class_idx,
  output logic              class_valid
`endif
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned PIPE   = MAC_LAT + 2;
  localparam int unsigned WORD_W = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, EMIT, FIN} state_t;

  state_t              state;
  logic [IDX_W-1:0]    neuron;
  logic [WORD_W-1:0]   word;
  logic [ADDR_W-1:0]   digit_base_q;
  logic [ACC_W-1:0]    acc;
  // Bit 0: ROM data valid this cycle; bit PIPE-1: mac_p valid this cycle.
  logic [PIPE-1:0]     tag_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      neuron       <= '0;
      word         <= '0;
      digit_base_q <= '0;
      acc          <= '0;
      tag_sr       <= '0;
      w_addr       <= '0;
      d_addr       <= '0;
      mac_a        <= '0;
      mac_b        <= '0;
      result       <= '0;
      result_idx   <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done   <= 1'b0;
      tag_sr <= {tag_sr[PIPE-2:0], state == FEED};
      if (tag_sr[0]) begin
        mac_a <= w_data;
        mac_b <= d_data;
      end
      if (tag_sr[PIPE-1]) acc <= acc + ACC_W'(mac_p);

      case (state)
        IDLE: begin
          if (start) begin
            digit_base_q <= digit_base;
            neuron       <= '0;
            word         <= '0;
            w_addr       <= '0;
            d_addr       <= digit_base;
            acc          <= '0;
            busy         <= 1'b1;
            state        <= FEED;
          end
        end
        FEED: begin
          if (word == WORD_W'(N_WORDS - 1)) begin
            state <= DRAIN;
          end else begin
            word   <= word + WORD_W'(1);
            w_addr <= w_addr + ADDR_W'(1);
            d_addr <= d_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Last partial product arrives with nothing behind it: fold it straight into the result.
          if (tag_sr[PIPE-1] && (tag_sr[PIPE-2:0] == '0)) begin
            result       <= acc + ACC_W'(mac_p);
            result_idx   <= neuron;
            result_valid <= 1'b1;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (neuron == IDX_W'(N_NEURONS - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              neuron <= neuron + IDX_W'(1);
              word   <= '0;
              w_addr <= ADDR_W'((32'(neuron) + 32'd1) * N_WORDS);
              d_addr <= digit_base_q;
              acc    <= '0;
              state  <= FEED;
            end
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARGMAX_EN
  logic [ACC_W-1:0] max_val;

  // Strict greater-than keeps the lowest index among equal maxima.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val     <= '0;
      class_idx   <= '0;
      class_valid <= 1'b0;
    end else if (state == IDLE && start) begin
      max_val     <= '0;
      class_idx   <= '0;
      class_valid <= 1'b0;
    end else if (state == EMIT && result_valid && result_ready) begin
      if (result > max_val) begin
        max_val   <= result;
        class_idx <= result_idx;
      end
      if (result_idx == IDX_W'(N_NEURONS - 1)) class_valid <= 1'b1;
    end
  end
`endif

endmodule
